// File: rtl/dds_tone_gen.sv
// DDS tone source: one PCM sample per AC97 frame, stepped on each synchronised
// rising edge of ready, with sine/square/triangle/sawtooth, attenuation and width.
module dds_tone_gen #(
  parameter int SAMPLE_W = 20,
  parameter int PHASE_W  = 24
) (
  input  logic                       clock_27mhz,
  input  logic                       reset,
  input  logic                       ready,
  input  logic [PHASE_W-1:0]         freq,
  input  logic [1:0]                 wave,
  input  logic [3:0]                 atten,
  input  logic                       enable,
  input  logic                       phase_clr,
  output logic signed [SAMPLE_W-1:0] pcm_data,
  output logic                       pcm_valid
);

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // Quarter-wave sine, 17 points including both end points.
  function automatic logic [19:0] sine_quarter(input logic [4:0] idx);
    logic [19:0] v;
    case (idx)
      5'd0:    v = 20'h00000;
      5'd1:    v = 20'h0C8BD;
      5'd2:    v = 20'h18F8B;
      5'd3:    v = 20'h25280;
      5'd4:    v = 20'h30FBC;
      5'd5:    v = 20'h3C56B;
      5'd6:    v = 20'h471CE;
      5'd7:    v = 20'h5133C;
      5'd8:    v = 20'h5A827;
      5'd9:    v = 20'h62F20;
      5'd10:   v = 20'h6A6D9;
      5'd11:   v = 20'h70E2C;
      5'd12:   v = 20'h7641A;
      5'd13:   v = 20'h7A7D0;
      5'd14:   v = 20'h7D8A5;
      5'd15:   v = 20'h7F623;
      default: v = 20'h7FFFF;
    endcase
    return v;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] atten_shift(
    input logic signed [SAMPLE_W-1:0] x,
    input logic [3:0]                 sh
  );
    return x >>> sh;
  endfunction

  logic ready_s1, ready_s2, ready_hist;
  logic [1:0] settle;
  logic armed;
  logic edge_det;

  // The armed flag keeps a ready that is already high out of reset from
  // counting as an edge; it needs one observed low level first.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      ready_s1   <= 1'b0;
      ready_s2   <= 1'b0;
      ready_hist <= 1'b0;
      settle     <= 2'b00;
      armed      <= 1'b0;
    end else begin
      ready_s1   <= ready;
      ready_s2   <= ready_s1;
      ready_hist <= ready_s2;
      settle     <= {settle[0], 1'b1};
      armed      <= armed | (settle[1] & ~ready_s2);
    end
  end

  assign edge_det = armed & ready_s2 & ~ready_hist;

  // ---- stage p0: shadow capture and phase update at the detected edge ----
  logic signed [PHASE_W-1:0] phase_p0;
  logic [1:0]                wave_p0;
  logic [3:0]                atten_p0;
  logic                      en_p0;
  logic                      vld_p0;

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      phase_p0 <= '0;
      wave_p0  <= '0;
      atten_p0 <= '0;
      en_p0    <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= edge_det;
      if (edge_det) begin
        wave_p0  <= wave;
        atten_p0 <= atten;
        en_p0    <= enable;
      end
      // freq is consumed in the capture cycle itself, so no shadow copy is kept
      if (phase_clr)
        phase_p0 <= '0;
      else if (edge_det && enable)
        phase_p0 <= phase_p0 + $signed(freq);
    end
  end

  logic [1:0]         quad;
  logic [3:0]         idx;
  logic [4:0]         tidx;
  logic [19:0]        tval;
  logic [18:0]        tri_u;
  logic [18:0]        tri_t;
  logic signed [19:0] raw_next;

  always_comb begin
    quad     = phase_p0[PHASE_W-1 -: 2];
    idx      = phase_p0[PHASE_W-3 -: 4];
    tidx     = quad[0] ? (5'd16 - {1'b0, idx}) : {1'b0, idx};
    tval     = sine_quarter(tidx);
    tri_u    = phase_p0[PHASE_W-2 -: 19];
    tri_t    = phase_p0[PHASE_W-1] ? ~tri_u : tri_u;
    raw_next = '0;
    case (wave_p0)
      WAVE_SINE:   raw_next = quad[1] ? $signed(20'd0 - tval) : $signed(tval);
      WAVE_SQUARE: raw_next = phase_p0[PHASE_W-1] ? 20'sh80001 : 20'sh7FFFF;
      WAVE_TRI:    raw_next = $signed({tri_t, 1'b0} ^ 20'h80000);
      WAVE_SAW:    raw_next = $signed(phase_p0[PHASE_W-1 -: 20] ^ 20'h80000);
      default:     raw_next = '0;
    endcase
  end

  // ---- stage p1: raw 20-bit waveform sample ----
  logic signed [19:0] raw_p1;
  logic [3:0]         atten_p1;
  logic               en_p1;
  logic               vld_p1;

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      raw_p1   <= '0;
      atten_p1 <= '0;
      en_p1    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        raw_p1   <= raw_next;
        atten_p1 <= atten_p0;
        en_p1    <= en_p0;
      end
    end
  end

  // ---- stage p2: width reduction, attenuation, output register ----
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= vld_p1;
      if (vld_p1)
        pcm_data <= en_p1 ? atten_shift($signed(raw_p1[19 -: SAMPLE_W]), atten_p1) : '0;
    end
  end

endmodule

// File: doc/dds_tone_gen.md
# dds_tone_gen

Parametrised direct-digital-synthesis tone source for the AC97 audio path. It produces one PCM sample per AC97 frame, advancing on each rising edge of the codec `ready` signal. It supports programmable frequency, four waveforms, attenuation and output width. It sits beside the AC97 controller in the audio top level and drives the left/right output mux, replacing the fixed-pitch sine and square generators.

## Interface
- `SAMPLE_W`, 20: output sample width, 8..20; the MSBs of the 20-bit internal sample.
- `PHASE_W`, 24: phase accumulator width, 20..32.
- `clock_27mhz  in  1`: system clock.
- `reset  in  1`: reset, synchronous, active-high; clock `clock_27mhz`.
- `ready  in  1`: AC97 frame ready, from the bit-clock domain; asynchronous to `clock_27mhz`.
- `freq  in  PHASE_W`: phase increment per sample; f_out = freq × 48 kHz / 2^PHASE_W.
- `wave  in  2`: waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- `atten  in  4`: arithmetic right shift applied to the output, 0..15.
- `enable  in  1`: when low, output is 0 and phase is held.
- `phase_clr  in  1`: single-cycle pulse that zeroes the phase.
- `pcm_data  out  SAMPLE_W`: signed two's-complement sample, held between updates.
- `pcm_valid  out  1`: one-cycle pulse when `pcm_data` updates.

## Operation
- `ready` passes through a 2-flop synchroniser plus one history flop. Edge E is the cycle where synchronised `ready` = 1 and history = 0.
- At E, capture `freq`, `wave`, `atten` and `enable` into shadow registers. These are the only values used for this sample, so mid-sample input changes have no effect.
- Phase: `ph <= ph + freq_s` (mod 2^PHASE_W) if `enable_s`; otherwise `ph` is held. The first sample after reset uses phase = freq.
- Sine: quarter-wave table T[0..16] = 00000, 0C8BD, 18F8B, 25280, 30FBC, 3C56B, 471CE, 5133C, 5A827, 62F20, 6A6D9, 70E2C, 7641A, 7A7D0, 7D8A5, 7F623, 7FFFF.
  - q = ph[P-1:P-2], i = ph[P-3:P-6].
  - q0 → T[i]; q1 → T[16-i]; q2 → −T[i]; q3 → −T[16-i]. Negation is 20-bit two's complement.
- Square: ph[P-1] = 0 → 7FFFF; ph[P-1] = 1 → 80001.
- Sawtooth: ph[P-1:P-20] XOR 80000.
- Triangle: u = ph[P-2:P-20] (19 bits); t = ph[P-1] ? ~u : u; value = {t, 1'b0} XOR 80000.
- Output path:
  - Take raw[19:20-SAMPLE_W], then arithmetic shift right by `atten_s` (sign-extending).
  - If `enable_s` = 0, output is 0. A valid pulse is still produced.
- `phase_clr`: `ph <= 0` in the following cycle. If it coincides with the phase-update cycle, the clear wins (ph = 0, no increment), and that sample is generated from phase 0.
- No internal state is cleared by `wave`/`freq` changes. The phase is continuous across waveform switches.

## Timing
- E: edge detected, inputs captured.
- E+1: `ph` updated.
- E+2: raw 20-bit sample registered.
- E+3: `pcm_data` registered and `pcm_valid` = 1 for exactly one cycle.
- Total latency is 3 cycles from E. This is far below the ~280 `clock_27mhz` cycles between `ready` rise and the AC97 latch at bit 255.
- `ready` must stay low for at least 3 `clock_27mhz` cycles between frames (guaranteed by AC97 timing). Glitch-free operation is not required for shorter pulses.
- Reset values:
  - `pcm_data` = 0, `pcm_valid` = 0, `ph` = 0.
  - Synchroniser and history flops = 0.
  - Shadow registers = 0; the pipeline is flushed.
- Reset asserted mid-pipeline: the pending sample is discarded and no `pcm_valid` is issued.
- `ready` already high when reset deasserts: no edge is seen until it goes low and rises again.

## Test plan
- Sine: SAMPLE_W = 20, PHASE_W = 24, freq = 0x040000, atten = 0, enable = 1.
  - Samples 1, 2, 16 → 0C8BD, 18F8B, 7FFFF.
  - Sample 32 → 00000; sample 33 → F3743; sample 48 → 80001.
  - Sequence repeats every 64 samples.
- Square: SAMPLE_W = 16, freq = 0x800000, atten = 4 → `pcm_data` alternates F800, 07FF, F800, …
- Sawtooth and triangle, freq = 0x100000:
  - Sawtooth sample 1 = 90000; sample 8 = 00000; sample 16 = 80000.
  - Triangle sample 1 = A0000; sample 8 = 7FFFE.
- Handshake: single `ready` rise → exactly one `pcm_valid`, 3 cycles after the synchronised edge. Holding `ready` high for 500 cycles produces no extra pulses. `freq` changed at E+1 does not affect the current sample.
- Control:
  - `phase_clr` asserted in the update cycle → sample = T[0] = 00000.
  - enable = 0 → `pcm_data` = 0 and phase frozen.
  - Re-enable → the sequence resumes from the held phase.
- Reset mid-pipeline (at E+2) → no `pcm_valid`, `pcm_data` = 0. The next `ready` edge yields the first sample (phase = freq).
